// File: rtl/maxpool2d2x2s2_window.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2d2x2s2_window
// Description : Forms 2x2 windows from the pixel stream plus the line-buffer
//               output and emits one max-pooled pixel per window (stride 2).
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2d2x2s2_window #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 98,
    parameter int IMG_HEIGHT  = 98,
    parameter int SIGNED_DATA = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  valid_in,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic [DATA_WIDTH-1:0] line_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  frame_done
);

    localparam int c_CW = $clog2(IMG_WIDTH);
    localparam int c_RW = $clog2(IMG_HEIGHT);

    localparam logic [c_CW-1:0] c_COL_MAX      = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_MAX      = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_CW-1:0] c_COL_PAIR_END = c_CW'(2 * (IMG_WIDTH / 2) - 1);
    localparam logic [c_RW-1:0] c_ROW_PAIR_END = c_RW'(2 * (IMG_HEIGHT / 2) - 1);

    localparam logic [1:0] c_S_FILL       = 2'd0;
    localparam logic [1:0] c_S_PAIR_LEFT  = 2'd1;
    localparam logic [1:0] c_S_PAIR_RIGHT = 2'd2;

    logic [c_CW-1:0]       r_col;
    logic [c_RW-1:0]       r_row;
    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_hold_max;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_last_out;
    logic                  r_frame_done;

    logic [c_CW-1:0]       w_cur_col;
    logic [c_RW-1:0]       w_cur_row;
    logic [1:0]            w_cur_state;
    logic [c_CW-1:0]       w_nxt_col;
    logic [c_RW-1:0]       w_nxt_row;
    logic [1:0]            w_nxt_state;
    logic                  w_col_wrap;
    logic                  w_load_hold;
    logic                  w_emit;
    logic                  w_last;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_pair_max;
    logic [DATA_WIDTH-1:0] w_win_max;

    function automatic logic [DATA_WIDTH-1:0] f_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic a_wins;
        if (SIGNED_DATA != 0) a_wins = ($signed(a) > $signed(b));
        else                  a_wins = (a > b);
        return a_wins ? a : b;
    endfunction

    // frame_start relabels the presented pixel as (0,0) in the FILL phase
    assign w_cur_col   = frame_start ? '0 : r_col;
    assign w_cur_row   = frame_start ? '0 : r_row;
    assign w_cur_state = frame_start ? c_S_FILL : r_state;

    assign w_col_wrap = (w_cur_col == c_COL_MAX);
    assign w_nxt_col  = w_col_wrap ? '0 : w_cur_col + c_CW'(1);
    assign w_nxt_row  = !w_col_wrap            ? w_cur_row :
                        (w_cur_row == c_ROW_MAX) ? '0 : w_cur_row + c_RW'(1);

    assign w_pair_max = f_max(pixel_in, line_in);
    assign w_win_max  = f_max(r_hold_max, w_pair_max);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_S_FILL;
        end else if (valid_in) begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = c_S_FILL;
        w_load_hold = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_done      = valid_in && (w_cur_col == c_COL_MAX) && (w_cur_row == c_ROW_MAX);

        // Phase of the next pixel follows purely from its row/column parity
        if (w_nxt_row[0]) begin
            w_nxt_state = w_nxt_col[0] ? c_S_PAIR_RIGHT : c_S_PAIR_LEFT;
        end

        if (valid_in) begin
            case (w_cur_state)
                c_S_PAIR_LEFT: begin
                    w_load_hold = 1'b1;
                end
                c_S_PAIR_RIGHT: begin
                    w_emit = 1'b1;
                    w_last = (w_cur_col == c_COL_PAIR_END) && (w_cur_row == c_ROW_PAIR_END);
                end
                default: begin
                    w_load_hold = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold_max   <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_last_out   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= w_emit;
            r_last_out   <= w_last;
            r_frame_done <= w_done;
            if (w_emit) begin
                r_data_out <= w_win_max;
            end
            if (valid_in) begin
                r_col <= w_nxt_col;
                r_row <= w_nxt_row;
                if (w_load_hold) begin
                    r_hold_max <= w_pair_max;
                end else if (frame_start) begin
                    r_hold_max <= '0;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign last_out   = r_last_out;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2d2x2s2_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool2d2x2s2_window
// Description : Scoreboard bench for maxpool2d2x2s2_window over several
//               frame geometries, stalls, resync, reset and signed compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool2d2x2s2_window;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    logic [3:0]      vin, fs;
    logic [3:0][7:0] pix, lin;
    wire  [3:0]      vout, lout, fdone;
    wire  [3:0][7:0] dout;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out3  = 0;

    typedef struct {
        int id;
        int kind;   // 0 = pooled pixel, 1 = frame_done
        int data;
        int last;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] img [0:97][0:97];

    // 0: 4x4 unsigned, 1: 4x4 signed, 2: 5x3 unsigned, 3: 98x98 unsigned
    maxpool2d2x2s2_window #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED_DATA(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .valid_in(vin[0]), .frame_start(fs[0]), .pixel_in(pix[0]),
        .line_in(lin[0]), .data_out(dout[0]), .valid_out(vout[0]), .last_out(lout[0]),
        .frame_done(fdone[0]));
    maxpool2d2x2s2_window #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED_DATA(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .valid_in(vin[1]), .frame_start(fs[1]), .pixel_in(pix[1]),
        .line_in(lin[1]), .data_out(dout[1]), .valid_out(vout[1]), .last_out(lout[1]),
        .frame_done(fdone[1]));
    maxpool2d2x2s2_window #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3), .SIGNED_DATA(0)) u_dut2 (
        .Clk(Clk), .Rst(Rst), .valid_in(vin[2]), .frame_start(fs[2]), .pixel_in(pix[2]),
        .line_in(lin[2]), .data_out(dout[2]), .valid_out(vout[2]), .last_out(lout[2]),
        .frame_done(fdone[2]));
    maxpool2d2x2s2_window #(.DATA_WIDTH(8), .IMG_WIDTH(98), .IMG_HEIGHT(98), .SIGNED_DATA(0)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .valid_in(vin[3]), .frame_start(fs[3]), .pixel_in(pix[3]),
        .line_in(lin[3]), .data_out(dout[3]), .valid_out(vout[3]), .last_out(lout[3]),
        .frame_done(fdone[3]));

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d,
                                        input bit sgn);
        logic [7:0] v [4];
        logic [7:0] res;
        int best;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        res  = v[0];
        best = sgn ? int'($signed(v[0])) : int'(v[0]);
        for (int i = 1; i < 4; i++) begin
            int x;
            x = sgn ? int'($signed(v[i])) : int'(v[i]);
            if (x > best) begin
                best = x;
                res  = v[i];
            end
        end
        return res;
    endfunction

    task automatic pop_check(input int k, input int kind, input int data, input int last);
        int idx[$];
        idx = sbq.find_first_index(item) with (item.id == k && item.kind == kind);
        if (idx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_%s on dut%0d: got pulse, required none (cycle %0d)",
                     (kind == 0) ? "valid_out" : "frame_done", k, cyc);
        end else begin
            exp_t e;
            e = sbq[idx[0]];
            sbq.delete(idx[0]);
            if (kind == 0) begin
                chk("data_out", data, e.data);
                chk("last_out", last, e.last);
                chk("out_cycle", cyc, e.cyc);
            end else begin
                chk("done_cycle", cyc, e.cyc);
            end
        end
    endtask

    // Monitor: consumes every DUT pulse against the scoreboard
    always @(negedge Clk) begin
        if (!Rst) begin
            for (int k = 0; k < 4; k++) begin
                if (vout[k]) begin
                    if (k == 3) n_out3++;
                    pop_check(k, 0, int'(dout[k]), int'(lout[k]));
                end else if (lout[k]) begin
                    chk("last_without_valid", int'(lout[k]), 0);
                end
                if (fdone[k]) pop_check(k, 1, 0, 0);
            end
        end
    end

    // Sends the first npix pixels of img as a w x h frame; stall<0 means random gaps
    task automatic run_frame(input int id, input int w, input int h, input int stall,
                             input bit sgn, input int npix, input bit use_fs);
        int n;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n < npix) begin
                    exp_t e;
                    int ns;
                    @(negedge Clk);
                    vin[id] = 1'b1;
                    fs[id]  = use_fs && (r == 0) && (c == 0);
                    pix[id] = img[r][c];
                    lin[id] = (r > 0) ? img[r-1][c] : 8'($urandom);
                    if ((r % 2 == 1) && (c % 2 == 1) && (c < 2 * (w / 2))) begin
                        e.id   = id;
                        e.kind = 0;
                        e.data = int'(max4(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c], sgn));
                        e.last = ((r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1)) ? 1 : 0;
                        e.cyc  = cyc + 1;
                        sbq.push_back(e);
                    end
                    if ((r == h - 1) && (c == w - 1)) begin
                        e.id = id; e.kind = 1; e.data = 0; e.last = 0; e.cyc = cyc + 1;
                        sbq.push_back(e);
                    end
                    n++;
                    ns = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                    repeat (ns) begin
                        @(negedge Clk);
                        vin[id] = 1'b0;
                        fs[id]  = 1'($urandom);
                        pix[id] = 8'($urandom);
                        lin[id] = 8'($urandom);
                    end
                end
            end
        end
        @(negedge Clk);
        vin[id] = 1'b0;
        fs[id]  = 1'b0;
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = 8'($urandom);
    endtask

    initial begin
        Rst = 1'b1;
        vin = '0;
        fs  = '0;
        pix = '0;
        lin = '0;
        repeat (3) @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_data_out", int'(dout[k]), 0);
            chk("reset_valid_out", int'(vout[k]), 0);
            chk("reset_last_out", int'(lout[k]), 0);
            chk("reset_frame_done", int'(fdone[k]), 0);
        end
        Rst = 1'b0;

        // 4x4 ramp, continuous then with 3-cycle gaps
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'(4 * r + c);
        run_frame(0, 4, 4, 0, 1'b0, 16, 1'b1);
        run_frame(0, 4, 4, 3, 1'b0, 16, 1'b1);

        // Signed vs unsigned window {-1, -128, 5, -7}
        fill_random(4, 4);
        img[0][0] = 8'hFF; img[0][1] = 8'h80;
        img[1][0] = 8'h05; img[1][1] = 8'hF9;
        run_frame(0, 4, 4, 0, 1'b0, 16, 1'b1);
        run_frame(1, 4, 4, 0, 1'b1, 16, 1'b1);

        // 5x3: unpaired column and trailing row must not leak into outputs
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                img[r][c] = (r == 2) ? 8'd250 : 8'd1;
        img[1][4] = 8'd200;
        run_frame(2, 5, 3, 0, 1'b0, 15, 1'b1);

        // Resync: abandon after (1,1), new frame_start lands where (2,1) would be
        fill_random(4, 4);
        run_frame(0, 4, 4, 0, 1'b0, 6, 1'b1);
        fill_random(4, 4);
        run_frame(0, 4, 4, 0, 1'b0, 16, 1'b1);

        // Reset mid-row 1 after a PAIR_LEFT load; next frame has no frame_start
        fill_random(4, 4);
        img[0][0] = 8'hAA;
        run_frame(0, 4, 4, 0, 1'b0, 7, 1'b1);
        #2 Rst = 1'b1;
        #1;
        chk("async_reset_data_out", int'(dout[0]), 0);
        chk("async_reset_valid_out", int'(vout[0]), 0);
        chk("async_reset_last_out", int'(lout[0]), 0);
        chk("async_reset_frame_done", int'(fdone[0]), 0);
        @(negedge Clk);
        Rst = 1'b0;
        fill_random(4, 4);
        run_frame(0, 4, 4, 0, 1'b0, 16, 1'b0);

        // Default geometry, random data and random gaps
        fill_random(98, 98);
        run_frame(3, 98, 98, -1, 1'b0, 98 * 98, 1'b1);

        repeat (5) @(negedge Clk);
        chk("out_count_98x98", n_out3, 2401);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool2d2x2s2_window.md
# maxpool2d2x2s2_window

Consumer end of the maxpool2d2x2s2 line-buffer path. Takes the raw pixel stream together with the line-buffer output (the same-column pixel from the previous row), tracks column and row position, and forms each 2x2 window. Emits one max-pooled pixel per window with stride 2, as a valid-qualified stream to the next layer. Also reports frame completion.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 98, pixels per input row (must be >= 2)
- IMG_HEIGHT, 98, rows per input frame (must be >= 2)
- SIGNED_DATA, 0, compare as unsigned when 0, as two's complement when 1
- Clk  input  1  clock, all logic on rising edge
- Rst  input  1  asynchronous, active-high reset
- valid_in  input  1  pixel_in/line_in qualify this cycle
- frame_start  input  1  marks pixel_in as row 0, column 0; sampled only when valid_in=1
- pixel_in  input  DATA_WIDTH  current-row pixel; also drives the line buffer data_in
- line_in  input  DATA_WIDTH  previous-row pixel at the same column; the line buffer data_out
- data_out  output  DATA_WIDTH  pooled pixel
- valid_out  output  1  one-cycle qualifier for data_out
- last_out  output  1  high with the final pooled pixel of a frame
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame

## Operation
- Integration:
  - The line buffer is instantiated with BUFFER_DEPTH = IMG_WIDTH-1, sharing pixel_in and valid_in.
  - Its registered output is then column-aligned with pixel_in.
  - line_in is don't-care during row 0.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1.
  - Both advance only on cycles with valid_in=1; col wraps to 0 and increments row.
  - row wraps to 0 after IMG_HEIGHT-1.
  - valid_in=0 freezes all state, including hold_max.
- frame_start with valid_in:
  - Forces the current pixel to position (0,0), and the counters become (col=1, row=0) after the edge.
  - hold_max and the phase are discarded, so a frame can resync mid-frame.
- State machine, one state per row parity:
  - FILL: even row. Pixels are only counted; no output.
  - PAIR_LEFT: odd row, even col. hold_max <= max(pixel_in, line_in).
  - PAIR_RIGHT: odd row, odd col. data_out <= max(hold_max, pixel_in, line_in), valid_out <= 1.
  - Transitions are evaluated on valid cycles. The state is a pure function of (row, col) after the update.
- Odd dimensions:
  - If IMG_WIDTH is odd, the final even column of an odd row is an unpaired PAIR_LEFT. hold_max loads, but nothing is emitted and the value is discarded.
  - If IMG_HEIGHT is odd, the final row is FILL and produces no output.
- Output count per frame is floor(IMG_WIDTH/2)*floor(IMG_HEIGHT/2). With the defaults this is 49*49 = 2401.
- max:
  - Uses the comparison selected by SIGNED_DATA.
  - Ties select either operand; the value is identical.
  - No width growth: data_out is DATA_WIDTH.
- last_out = valid_out for the window whose right pixel sits at (col=2*floor(IMG_WIDTH/2)-1, row=2*floor(IMG_HEIGHT/2)-1).
- frame_done pulses on the cycle after the valid pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.

## Timing
- Reset (asynchronous, active-high):
  - Outputs: data_out=0, valid_out=0, last_out=0, frame_done=0.
  - Internal state: col=0, row=0, hold_max=0, state FILL.
  - A reset mid-frame abandons the frame; the next valid pixel is (0,0).
- Latency: valid_out rises on the clock edge that accepts the PAIR_RIGHT pixel, i.e. it is visible 1 cycle after that pixel is presented.
- valid_out, last_out and frame_done are single-cycle pulses.
- data_out holds its last value when valid_out=0.
- No backpressure: the downstream side must accept every valid_out cycle.
- Back-to-back valid_in sustains one output every 2 input cycles during odd rows.
- A gap between PAIR_LEFT and PAIR_RIGHT is allowed and is unbounded; hold_max is retained across it.
- frame_done and last_out coincide when both IMG_WIDTH and IMG_HEIGHT are even.

## Test plan
- Ramp on 4x4 (IMG_WIDTH=IMG_HEIGHT=4):
  - Stimulus: pixel = 4*row+col, continuous valid_in, with a behavioural line-buffer model.
  - Required outputs: 5, 7, 13, 15, with valid_out pulses 2 cycles apart.
  - last_out with the 15; frame_done on the same cycle.
- Odd dimensions 5x3:
  - Stimulus: all pixels 1, except (4,1)=200 and row 2 = 250.
  - Required: exactly 2 outputs, both 1. The unpaired column and final row are ignored.
  - frame_done 1 cycle after pixel (4,2).
- Stalls:
  - Stimulus: the 4x4 ramp with valid_in low for 3 cycles between every pixel.
  - Required: identical output values.
  - Each valid_out lands 1 cycle after its PAIR_RIGHT pixel.
- Signed compare with SIGNED_DATA=1:
  - Window {-1, -128, 5, -7} (0xFF, 0x80, 0x05, 0xF9) -> data_out 0x05.
  - The same window with SIGNED_DATA=0 -> 0xFF.
- Resync and reset:
  - Assert frame_start at (2,1) of a 4x4 frame -> the counters restart and the next 16 pixels yield 4 correct outputs.
  - Assert Rst mid-row 1 -> all outputs read 0 immediately, and no stale output is emitted afterwards.
- Default 98x98 random frame: exactly 2401 outputs, matching the reference-model max, with last_out on the 2401st output only.
